// File: rtl/debug_sequencer.sv
// UART-driven debug sequencer for the MIPS pipeline: loads instruction memory,
// runs or single-steps the pipeline, then streams the PC and register file to the host.
//
// state     | meaning
// IDLE      | wait for a command byte
// LOAD_CNT  | receive word count N (0 means 256)
// LOAD_DATA | assemble words LSB first, write to imem, flush pipeline when done
// RUN       | pipeline enabled until halt
// STEP      | pipeline enabled for one cycle
// DUMP_TX   | wait for transmitter idle, launch next byte
// DUMP_GAP  | one-cycle spacing between bytes
module debug_sequencer #(
  parameter int NBITS     = 32,
  parameter int IMEM_ADDR = 8,
  parameter int REG_ADDR  = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx_valid,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_tx_busy,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  input  logic                 i_halt,
  input  logic [NBITS-1:0]     i_pc,
  input  logic [NBITS-1:0]     i_reg_data,
  output logic [REG_ADDR-1:0]  o_reg_addr,
  output logic                 o_pipe_en,
  output logic                 o_pipe_rst,
  output logic                 o_imem_we,
  output logic [IMEM_ADDR-1:0] o_imem_addr,
  output logic [NBITS-1:0]     o_imem_data
);

  localparam int NB         = NBITS / 8;
  localparam int BI_W       = (NB > 1) ? $clog2(NB) : 1;
  localparam int NREGS      = 1 << REG_ADDR;
  localparam int WD_W       = REG_ADDR + 1;
  localparam int IMEM_DEPTH = 1 << IMEM_ADDR;
  localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(NB - 1);
  // Dump word 0 is the PC, words 1..NREGS are registers; NREGS+1 marks completion.
  localparam logic [WD_W-1:0] DUMP_END  = WD_W'(NREGS + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_CNT, LOAD_DATA, RUN, STEP, DUMP_TX, DUMP_GAP
  } state_t;

  state_t               state_q, state_d;
  logic [8:0]           cnt_q, cnt_d;
  logic [8:0]           widx_q, widx_d;
  logic [BI_W-1:0]      lbyte_q, lbyte_d;
  logic [NBITS-1:0]     asm_q, asm_d;
  logic                 we_q, we_d;
  logic [IMEM_ADDR-1:0] waddr_q, waddr_d;
  logic [NBITS-1:0]     wdata_q, wdata_d;
  logic                 prst_q, prst_d;
  logic [WD_W-1:0]      dword_q, dword_d;
  logic [BI_W-1:0]      dbyte_q, dbyte_d;
  logic [NBITS-1:0]     sh_q, sh_d;
  logic                 start_q, start_d;
  logic [7:0]           txd_q, txd_d;
  logic [REG_ADDR-1:0]  raddr_q, raddr_d;

  logic [NBITS-1:0] word_nxt;
  logic [NBITS-1:0] out_word;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      lbyte_q <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      prst_q  <= 1'b0;
      dword_q <= '0;
      dbyte_q <= '0;
      sh_q    <= '0;
      start_q <= 1'b0;
      txd_q   <= '0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      lbyte_q <= lbyte_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      prst_q  <= prst_d;
      dword_q <= dword_d;
      dbyte_q <= dbyte_d;
      sh_q    <= sh_d;
      start_q <= start_d;
      txd_q   <= txd_d;
      raddr_q <= raddr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    widx_d   = widx_q;
    lbyte_d  = lbyte_q;
    asm_d    = asm_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    prst_d   = 1'b0;
    dword_d  = dword_q;
    dbyte_d  = dbyte_q;
    sh_d     = sh_q;
    start_d  = 1'b0;
    txd_d    = txd_q;
    raddr_d  = raddr_q;
    word_nxt = (asm_q >> 8) | (NBITS'(i_rx_data) << (NBITS - 8));
    out_word = '0;

    case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            8'h4C:   state_d = LOAD_CNT;
            8'h52:   state_d = RUN;
            8'h53:   state_d = STEP;
            8'h44:   state_d = DUMP_TX;
            default: state_d = IDLE;
          endcase
        end
      end
      LOAD_CNT: begin
        if (i_rx_valid) begin
          cnt_d   = (i_rx_data == 8'h00) ? 9'd256 : {1'b0, i_rx_data};
          widx_d  = '0;
          lbyte_d = '0;
          asm_d   = '0;
          state_d = LOAD_DATA;
        end
      end
      LOAD_DATA: begin
        if (widx_q == cnt_q) begin
          prst_d  = 1'b1;
          state_d = IDLE;
        end else if (i_rx_valid) begin
          asm_d = word_nxt;
          if (lbyte_q == LAST_BYTE) begin
            lbyte_d = '0;
            widx_d  = widx_q + 9'd1;
            // Words beyond the memory depth are consumed but never written.
            if (int'(widx_q) < IMEM_DEPTH) begin
              we_d    = 1'b1;
              waddr_d = IMEM_ADDR'(widx_q);
              wdata_d = word_nxt;
            end
          end else begin
            lbyte_d = lbyte_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (i_halt) state_d = DUMP_TX;
      end
      STEP: begin
        state_d = DUMP_TX;
      end
      DUMP_TX: begin
        if (!i_tx_busy) begin
          out_word = (dbyte_q == '0) ? ((dword_q == '0) ? i_pc : i_reg_data) : sh_q;
          txd_d    = out_word[7:0];
          sh_d     = out_word >> 8;
          start_d  = 1'b1;
          state_d  = DUMP_GAP;
          if (dbyte_q == LAST_BYTE) begin
            dbyte_d = '0;
            dword_d = dword_q + 1'b1;
            if (dword_q != '0) raddr_d = raddr_q + 1'b1;
          end else begin
            dbyte_d = dbyte_q + 1'b1;
          end
        end
      end
      DUMP_GAP: begin
        if (dword_q == DUMP_END) begin
          dword_d = '0;
          raddr_d = '0;
          state_d = IDLE;
        end else begin
          state_d = DUMP_TX;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Combinational so the pipeline stops in the very cycle halt is seen.
  assign o_pipe_en   = (state_q == STEP) || ((state_q == RUN) && !i_halt);
  assign o_pipe_rst  = prst_q;
  assign o_imem_we   = we_q;
  assign o_imem_addr = waddr_q;
  assign o_imem_data = wdata_q;
  assign o_tx_start  = start_q;
  assign o_tx_data   = txd_q;
  assign o_reg_addr  = raddr_q;

endmodule

// File: tb/tb_debug_sequencer.sv
// Scoreboard bench for debug_sequencer: expected imem writes and TX bytes are queued
// by the stimulus and popped by a monitor whenever the DUT presents them.
module tb_debug_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        i_tx_busy;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        i_halt;
  logic [31:0] i_pc;
  logic [31:0] i_reg_data;
  logic [4:0]  o_reg_addr;
  logic        o_pipe_en;
  logic        o_pipe_rst;
  logic        o_imem_we;
  logic [7:0]  o_imem_addr;
  logic [31:0] o_imem_data;

  always #5 clk = ~clk;

  debug_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .i_tx_busy(i_tx_busy), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .i_halt(i_halt), .i_pc(i_pc), .i_reg_data(i_reg_data), .o_reg_addr(o_reg_addr),
    .o_pipe_en(o_pipe_en), .o_pipe_rst(o_pipe_rst),
    .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data)
  );

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, we_cnt = 0, prst_cnt = 0, tx_cnt = 0;
  int en_cnt = 0, halt_at = 0, busy_len = 0, busy_cnt = 0;
  int last_start_cyc = 0, last_we_cyc = 0;
  int b_we, b_prst, b_tx, b_en;
  bit busy_hold = 1'b0;

  // Pipeline / register file / UART TX models
  assign i_halt     = (en_cnt >= halt_at);
  assign i_reg_data = 32'(o_reg_addr) * 32'h01010101;
  assign i_tx_busy  = busy_hold || (busy_cnt > 0);

  always @(posedge clk) begin
    if (o_pipe_en) en_cnt <= en_cnt + 1;
    if (o_tx_start) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t        e;
    logic [7:0] eb;
    cyc++;
    if (rst_n) begin
      if (o_imem_we) begin
        we_cnt++;
        last_we_cyc = cyc;
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", o_imem_addr, o_imem_data);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", 64'(o_imem_addr), 64'(e.a));
          check("wr_data", 64'(o_imem_data), 64'(e.d));
        end
      end
      if (o_pipe_rst) begin
        prst_cnt++;
        check("prst_after_we", 64'(cyc - last_we_cyc), 64'd1);
      end
      if (o_tx_start) begin
        check("tx_start_while_busy", 64'(i_tx_busy), 64'd0);
        if (tx_cnt > 0) check("tx_spacing", 64'((cyc - last_start_cyc) >= 2), 64'd1);
        tx_cnt++;
        last_start_cyc = cyc;
        if (exp_tx.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_unexpected: got byte %0h expected none", o_tx_data);
        end else begin
          eb = exp_tx.pop_front();
          check("tx_byte", 64'(o_tx_data), 64'(eb));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic snap();
    b_we = we_cnt; b_prst = prst_cnt; b_tx = tx_cnt; b_en = en_cnt;
  endtask

  task automatic push_dump();
    exp_tx.push_back(8'h28); exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
    for (int k = 0; k < 32; k++)
      for (int j = 0; j < 4; j++) exp_tx.push_back(8'(k));
  endtask

  task automatic wait_tx(input string name, input int target, input int budget);
    int i = 0;
    while (tx_cnt < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, 64'(tx_cnt), 64'(target));
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int j = 0; j < 4; j++) send(w[8*j +: 8]);
  endtask

  initial begin
    int t0, t1;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    i_pc       = 32'h28;
    rst_n      = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    check("rst_tx_start", 64'(o_tx_start), 64'd0);
    check("rst_tx_data", 64'(o_tx_data), 64'd0);
    check("rst_imem_we", 64'(o_imem_we), 64'd0);
    check("rst_imem_addr", 64'(o_imem_addr), 64'd0);
    check("rst_imem_data", 64'(o_imem_data), 64'd0);
    check("rst_pipe_en", 64'(o_pipe_en), 64'd0);
    check("rst_pipe_rst", 64'(o_pipe_rst), 64'd0);
    check("rst_reg_addr", 64'(o_reg_addr), 64'd0);

    snap();
    send(8'h41);
    idle(5);
    check("ign_we", 64'(we_cnt - b_we), 64'd0);
    check("ign_tx", 64'(tx_cnt - b_tx), 64'd0);
    check("ign_en", 64'(en_cnt - b_en), 64'd0);
    check("ign_prst", 64'(prst_cnt - b_prst), 64'd0);

    exp_wr.push_back('{a: 8'd0, d: 32'h12345678});
    exp_wr.push_back('{a: 8'd1, d: 32'hDEADBEEF});
    snap();
    send(8'h4C); send(8'h02);
    send_word(32'h12345678); send_word(32'hDEADBEEF);
    idle(5);
    check("load_we_cycles", 64'(we_cnt - b_we), 64'd2);
    check("load_prst_pulses", 64'(prst_cnt - b_prst), 64'd1);
    check("load_wr_drained", 64'(exp_wr.size()), 64'd0);
    check("load_no_en", 64'(en_cnt - b_en), 64'd0);

    busy_len = 10;
    halt_at  = en_cnt + 10;
    push_dump();
    snap();
    send(8'h52);
    wait_tx("run_dump_bytes", b_tx + 132, 5000);
    idle(3);
    check("run_en_cycles", 64'(en_cnt - b_en), 64'd10);
    check("run_tx_drained", 64'(exp_tx.size()), 64'd0);

    busy_len = 0;
    push_dump();
    snap();
    send(8'h53);
    wait_tx("step_first_byte", b_tx + 1, 50);
    t0 = last_start_cyc;
    wait_tx("step_dump_bytes", b_tx + 132, 1000);
    t1 = last_start_cyc;
    idle(3);
    check("dump_span_cycles", 64'(t1 - t0), 64'd262);
    check("step_en_cycles", 64'(en_cnt - b_en), 64'd1);

    push_dump();
    snap();
    send(8'h53);
    wait_tx("step2_dump_bytes", b_tx + 132, 1000);
    idle(3);
    check("step2_en_cycles", 64'(en_cnt - b_en), 64'd1);

    busy_hold = 1'b1;
    push_dump();
    snap();
    send(8'h44);
    idle(50);
    check("busy_no_start", 64'(tx_cnt - b_tx), 64'd0);
    send(8'h53);
    idle(5);
    busy_hold = 1'b0;
    busy_len  = 3;
    wait_tx("busy_dump_bytes", b_tx + 132, 2000);
    idle(5);
    check("busy_step_dropped", 64'(en_cnt - b_en), 64'd0);
    check("busy_tx_drained", 64'(exp_tx.size()), 64'd0);
    check("busy_no_extra", 64'(tx_cnt - b_tx), 64'd132);

    exp_wr.push_back('{a: 8'd0, d: 32'h12345678});
    snap();
    send(8'h4C); send(8'h02);
    send_word(32'h12345678); send(8'hEF);
    idle(2);
    check("midrst_first_we", 64'(we_cnt - b_we), 64'd1);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(5);
    check("midrst_no_we", 64'(we_cnt - b_we), 64'd1);
    check("midrst_no_prst", 64'(prst_cnt - b_prst), 64'd0);

    exp_wr.push_back('{a: 8'd0, d: 32'h44332211});
    send(8'h4C); send(8'h01);
    send_word(32'h44332211);
    idle(5);
    check("reload_we", 64'(we_cnt - b_we), 64'd2);
    check("reload_prst", 64'(prst_cnt - b_prst), 64'd1);
    check("reload_wr_drained", 64'(exp_wr.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
